// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults and width helpers for the reg_pipe datapath buffer.
package reg_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;
    localparam int DEF_NCH   = 2;

    // Channel-select width; a single channel still gets a one-bit select port.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Occupancy counter width, wide enough to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one WIDTH-bit data register plus its valid flop.
// Macro REG_PIPE_RESET_DATA_EN: when defined, reset and clear also load RESET_VAL
// into the data register; otherwise the data flops carry no reset at all.
module reg_pipe_stage #(
    parameter int WIDTH = 8
`ifdef REG_PIPE_RESET_DATA_EN
    , parameter logic [WIDTH-1:0] RESET_VAL = '0
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             v_in,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    // Valid bit empties on reset or flush, otherwise takes the upstream valid on load.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            v <= 1'b0;
        end else if (load) begin
            v <= v_in;
        end
    end

`ifdef REG_PIPE_RESET_DATA_EN
    // Data returns to RESET_VAL on reset/flush and captures only real words otherwise.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            q <= RESET_VAL;
        end else if (load && v_in) begin
            q <= d;
        end
    end
`else
    // Data captures only real words, so a bubble passing through leaves the old value held.
    always_ff @(posedge clock) begin
        if (load && v_in) begin
            q <= d;
        end
    end
`endif

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing,
// flush and an NCH-way input selector.
// Macro REG_PIPE_RESET_DATA_EN: when defined, stage data registers reset to RESET_VAL.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter int               NCH       = DEF_NCH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NCH*WIDTH-1:0]          in_data,
    input  logic [sel_width(NCH)-1:0]     in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int SW = sel_width(NCH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] stage_v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] ld;
    logic             in_xfer;
    logic             out_xfer;

`ifndef REG_PIPE_RESET_DATA_EN
    // RESET_VAL only matters when data reset is built in; kept as a named unused tie-off.
    logic [WIDTH-1:0] unused_reset_val;
    assign unused_reset_val = RESET_VAL;
`endif

    // Input selector: any select value outside the channel range falls back to channel 0.
    always_comb begin
        sel_data = in_data[WIDTH-1:0];
        for (int c = 1; c < NCH; c++) begin
            if (in_sel == SW'(c)) begin
                sel_data = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Advance chain from the tail back: a stage moves when the slot ahead is empty or moving.
    always_comb begin
        adv = '0;
        ld  = '0;
        adv[DEPTH-1] = stage_v[DEPTH-1] & out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = stage_v[k] & (~stage_v[k+1] | adv[k+1]);
        end
        for (int k = 0; k < DEPTH; k++) begin
            ld[k] = ~stage_v[k] | adv[k];
        end
    end

    assign in_ready  = ld[0] & ~flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = stage_v[DEPTH-1] & ~flush;
    assign out_xfer  = out_valid & out_ready;
    assign out_data  = stage_q[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_k;
        logic             v_k;

        if (k == 0) begin : g_head
            assign d_k = sel_data;
            assign v_k = in_xfer;
        end else begin : g_body
            assign d_k = stage_q[k-1];
            assign v_k = stage_v[k-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH)
`ifdef REG_PIPE_RESET_DATA_EN
            , .RESET_VAL (RESET_VAL)
`endif
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .clear (flush),
            .load  (ld[k]),
            .d     (d_k),
            .v_in  (v_k),
            .q     (stage_q[k]),
            .v     (stage_v[k])
        );
    end

    // Occupancy tracks transfers in and out; a simultaneous pair leaves it unchanged.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed and randomized checks of reg_pipe against a word-position model.
// Macro REG_PIPE_RESET_DATA_EN: when defined, the post-reset out_data value is also checked.
module tb_reg_pipe;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 3;
    localparam int         NCH       = 3;
    localparam logic [7:0] RESET_VAL = 8'h5A;

    logic                 clock     = 1'b0;
    logic                 reset     = 1'b0;
    logic [NCH*WIDTH-1:0] in_data   = '0;
    logic [1:0]           in_sel    = '0;
    logic                 in_valid  = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 flush     = 1'b0;
    logic [1:0]           count;

    int total = 0;
    int bad   = 0;

    // Model: words in arrival order with the stage index each one currently sits in.
    logic [7:0] m_data [$];
    int         m_pos  [$];
    int         m_np   [$];
    bit         m_live = 1'b0;
    bit         m_pop;
    bit         exp_ov;
    bit         exp_ir;
    int         m_lim;
    int         m_p;

    reg_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .NCH       (NCH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] pick(input logic [NCH*WIDTH-1:0] d, input logic [1:0] s);
        int ch;
        ch = (int'(s) < NCH) ? int'(s) : 0;
        return d[ch*WIDTH +: WIDTH];
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [1:0] sel, input logic ordy,
                                 input logic fl, input logic rst);
        @(posedge clock);
        #1;
        in_valid  = v;
        in_data   = {d2, d1, d0};
        in_sel    = sel;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clock);
    endtask

    task automatic send(input logic v, input logic [7:0] d, input logic ordy);
        applyStimulus(v, d, ~d, 8'hEE, 2'd0, ordy, 1'b0, 1'b0);
    endtask

    // Every cycle: derive expected outputs from word positions, compare, then advance the model.
    always @(negedge clock) begin
        if (m_live) begin
            exp_ov = !flush && (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
            m_pop  = exp_ov && out_ready;
            m_np.delete();
            m_lim = DEPTH;
            for (int i = (m_pop ? 1 : 0); i < m_pos.size(); i++) begin
                m_p = m_pos[i] + 1;
                if (m_p > m_lim - 1) m_p = m_lim - 1;
                m_np.push_back(m_p);
                m_lim = m_p;
            end
            exp_ir = !flush && ((m_np.size() == 0) || (m_np[m_np.size()-1] > 0));

            checkOutput("model_out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov) checkOutput("model_out_data", {24'd0, out_data}, {24'd0, m_data[0]});
            checkOutput("model_in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            checkOutput("model_count", {30'd0, count}, m_data.size());

            if (reset || flush) begin
                m_data.delete();
                m_pos.delete();
            end else begin
                if (m_pop) void'(m_data.pop_front());
                m_pos = m_np;
                if (in_valid && exp_ir) begin
                    m_data.push_back(pick(in_data, in_sel));
                    m_pos.push_back(0);
                end
            end
        end
        if (reset) begin
            m_data.delete();
            m_pos.delete();
            m_live = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int thresh;

        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);

        // Streaming after reset
        send(1'b1, 8'h11, 1'b1);
        checkOutput("rst_count", {30'd0, count}, 0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
`ifdef REG_PIPE_RESET_DATA_EN
        checkOutput("rst_out_data", {24'd0, out_data}, 32'h5A);
`endif
        send(1'b1, 8'h22, 1'b1);
        checkOutput("s2_count", {30'd0, count}, 1);
        send(1'b1, 8'h33, 1'b1);
        checkOutput("s3_count", {30'd0, count}, 2);
        checkOutput("s3_out_valid", {31'd0, out_valid}, 0);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("s4_out_valid", {31'd0, out_valid}, 1);
        checkOutput("s4_out_data", {24'd0, out_data}, 32'h11);
        checkOutput("s4_count", {30'd0, count}, 3);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("s5_out_data", {24'd0, out_data}, 32'h22);
        checkOutput("s5_count", {30'd0, count}, 2);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("s6_out_data", {24'd0, out_data}, 32'h33);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("s7_out_valid", {31'd0, out_valid}, 0);
        checkOutput("s7_count", {30'd0, count}, 0);

        // Backpressure with five words
        send(1'b1, 8'h01, 1'b0);
        send(1'b1, 8'h02, 1'b0);
        send(1'b1, 8'h03, 1'b0);
        checkOutput("b3_in_ready", {31'd0, in_ready}, 1);
        send(1'b1, 8'h04, 1'b0);
        checkOutput("b4_in_ready", {31'd0, in_ready}, 0);
        checkOutput("b4_count", {30'd0, count}, 3);
        send(1'b1, 8'h04, 1'b0);
        checkOutput("b5_in_ready", {31'd0, in_ready}, 0);
        send(1'b1, 8'h04, 1'b1);
        checkOutput("b6_in_ready", {31'd0, in_ready}, 1);
        checkOutput("b6_out_data", {24'd0, out_data}, 32'h01);
        send(1'b1, 8'h05, 1'b1);
        checkOutput("b7_out_data", {24'd0, out_data}, 32'h02);
        checkOutput("b7_count", {30'd0, count}, 3);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("b8_out_data", {24'd0, out_data}, 32'h03);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("b9_out_data", {24'd0, out_data}, 32'h04);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("b10_out_data", {24'd0, out_data}, 32'h05);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("b11_count", {30'd0, count}, 0);

        // Bubble collapse against a stalled tail
        send(1'b1, 8'hA1, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        send(1'b1, 8'hA2, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        checkOutput("c6_count", {30'd0, count}, 2);
        checkOutput("c6_in_ready", {31'd0, in_ready}, 1);
        checkOutput("c6_out_data", {24'd0, out_data}, 32'hA1);
        send(1'b0, 8'h00, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("c8_out_data", {24'd0, out_data}, 32'hA2);
        send(1'b0, 8'h00, 1'b1);

        // Channel select including an out-of-range select
        applyStimulus(1'b1, 8'hAA, 8'hBB, 8'hCC, 2'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hAA, 8'hBB, 8'hCC, 2'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hAA, 8'hBB, 8'hCC, 2'd2, 1'b1, 1'b0, 1'b0);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("d_sel1", {24'd0, out_data}, 32'hBB);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("d_sel3", {24'd0, out_data}, 32'hAA);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("d_sel2", {24'd0, out_data}, 32'hCC);
        send(1'b0, 8'h00, 1'b1);

        // Flush with a simultaneous input offer
        send(1'b1, 8'h61, 1'b0);
        send(1'b1, 8'h62, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h63, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("e_flush_in_ready", {31'd0, in_ready}, 0);
        checkOutput("e_flush_out_valid", {31'd0, out_valid}, 0);
        checkOutput("e_flush_count", {30'd0, count}, 2);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("e_after_count", {30'd0, count}, 0);
        checkOutput("e_after_out_valid", {31'd0, out_valid}, 0);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("e_late_out_valid", {31'd0, out_valid}, 0);

        // Reset while full
        send(1'b1, 8'h71, 1'b0);
        send(1'b1, 8'h72, 1'b0);
        send(1'b1, 8'h73, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        checkOutput("f_full_count", {30'd0, count}, 3);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        checkOutput("f_rst_count", {30'd0, count}, 0);
        checkOutput("f_rst_out_valid", {31'd0, out_valid}, 0);
        checkOutput("f_rst_in_ready", {31'd0, in_ready}, 1);
`ifdef REG_PIPE_RESET_DATA_EN
        checkOutput("f_rst_out_data", {24'd0, out_data}, 32'h5A);
`endif
        send(1'b0, 8'h00, 1'b1);
        checkOutput("f_late_out_valid", {31'd0, out_valid}, 0);

        // Randomized traffic with phases of light and heavy backpressure
        for (int n = 0; n < 3000; n++) begin
            thresh = ((n / 400) % 2 == 0) ? 80 : 25;
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
                          2'($urandom_range(0, 3)), $urandom_range(0, 99) < thresh,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
